// File: rtl/aclk_multi_alarm_if.sv
// Bundles the time, alarm-write, button and status signals between the
// time/key logic and the multi-alarm block.
interface aclk_multi_alarm_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
);
  logic                  minute_tick;
  logic [3:0]            cur_ms_hr;
  logic [3:0]            cur_ls_hr;
  logic [3:0]            cur_ms_min;
  logic [3:0]            cur_ls_min;
  logic                  load_new_a;
  logic [IDX_W-1:0]      alarm_sel;
  logic [3:0]            new_alarm_ms_hr;
  logic [3:0]            new_alarm_ls_hr;
  logic [3:0]            new_alarm_ms_min;
  logic [3:0]            new_alarm_ls_min;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  snooze_button;
  logic                  stop_button;
  logic                  sound_alarm;
  logic                  snoozing;
  logic [IDX_W-1:0]      alarm_active_idx;
  logic [3:0]            rd_alarm_ms_hr;
  logic [3:0]            rd_alarm_ls_hr;
  logic [3:0]            rd_alarm_ms_min;
  logic [3:0]            rd_alarm_ls_min;
  logic [1:0]            dbg_state;

  // Strobes (minute_tick, load_new_a, buttons) are single-cycle pulses with no
  // back-pressure; every other input is a level sampled on each clock edge.
  modport master (
    output minute_tick, cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min,
    output load_new_a, alarm_sel,
    output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    output alarm_en, snooze_button, stop_button,
    input  sound_alarm, snoozing, alarm_active_idx,
    input  rd_alarm_ms_hr, rd_alarm_ls_hr, rd_alarm_ms_min, rd_alarm_ls_min,
    input  dbg_state
  );

  modport slave (
    input  minute_tick, cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min,
    input  load_new_a, alarm_sel,
    input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    input  alarm_en, snooze_button, stop_button,
    output sound_alarm, snoozing, alarm_active_idx,
    output rd_alarm_ms_hr, rd_alarm_ls_hr, rd_alarm_ms_min, rd_alarm_ls_min,
    output dbg_state
  );
endinterface

// File: rtl/aclk_multi_alarm.sv
// NUM_ALARMS-channel BCD alarm store with once-per-minute match detection and
// a ringing / snooze / timeout controller driving sound_alarm.
module aclk_multi_alarm #(
  parameter int NUM_ALARMS       = 4,
  parameter int IDX_W            = 2,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic             clk,
  input  logic             reset,
  aclk_multi_alarm_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_MIN - 1);
  localparam logic [7:0] SNOOZE_LOAD = 8'(SNOOZE_MIN);

  logic [NUM_ALARMS-1:0][15:0] alarm_q;
  state_e                      state_q;
  logic [7:0]                  ring_cnt_q;
  logic [7:0]                  snooze_cnt_q;
  logic [IDX_W-1:0]            active_idx_q;
  logic                        sound_q;
  logic                        snoozing_q;

  logic [15:0]      cur_time;
  logic [15:0]      rd_word_d;
  logic [IDX_W-1:0] winner_d;
  logic             any_match_d;
  logic             active_en_d;
  logic             trigger;

  assign cur_time = {bus.cur_ms_hr, bus.cur_ls_hr, bus.cur_ms_min, bus.cur_ls_min};

  // Out-of-range alarm_sel matches no channel, so writes drop and readback is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (bus.load_new_a && (bus.alarm_sel == IDX_W'(i))) begin
          alarm_q[i] <= {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr,
                         bus.new_alarm_ms_min, bus.new_alarm_ls_min};
        end
      end
    end
  end

  // Descending scan so the lowest matching index is the one left in winner_d.
  always_comb begin
    winner_d    = '0;
    any_match_d = 1'b0;
    active_en_d = 1'b0;
    rd_word_d   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (bus.alarm_en[i] && (alarm_q[i] == cur_time)) begin
        winner_d    = IDX_W'(i);
        any_match_d = 1'b1;
      end
    end
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (active_idx_q == IDX_W'(i)) active_en_d = bus.alarm_en[i];
      if (bus.alarm_sel == IDX_W'(i)) rd_word_d = alarm_q[i];
    end
  end

  assign trigger = bus.minute_tick && any_match_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      active_idx_q <= '0;
      sound_q      <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q      <= ST_RINGING;
            ring_cnt_q   <= '0;
            active_idx_q <= winner_d;
            sound_q      <= 1'b1;
            snoozing_q   <= 1'b0;
          end
        end
        ST_RINGING: begin
          if (bus.stop_button || !active_en_d) begin
            state_q    <= ST_IDLE;
            sound_q    <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (bus.snooze_button) begin
            state_q      <= ST_SNOOZE;
            snooze_cnt_q <= SNOOZE_LOAD;
            sound_q      <= 1'b0;
            snoozing_q   <= 1'b1;
          end else if (trigger) begin
            ring_cnt_q   <= '0;
            active_idx_q <= winner_d;
          end else if (bus.minute_tick) begin
            if (ring_cnt_q == RING_LAST) begin
              state_q    <= ST_IDLE;
              sound_q    <= 1'b0;
              snoozing_q <= 1'b0;
            end else begin
              ring_cnt_q <= ring_cnt_q + 8'd1;
            end
          end
        end
        ST_SNOOZE: begin
          // Snooze presses are deliberately not decoded here: no extension.
          if (bus.stop_button || !active_en_d) begin
            state_q    <= ST_IDLE;
            sound_q    <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (trigger) begin
            state_q      <= ST_RINGING;
            ring_cnt_q   <= '0;
            active_idx_q <= winner_d;
            sound_q      <= 1'b1;
            snoozing_q   <= 1'b0;
          end else if (bus.minute_tick) begin
            if (snooze_cnt_q <= 8'd1) begin
              state_q      <= ST_RINGING;
              ring_cnt_q   <= '0;
              snooze_cnt_q <= '0;
              sound_q      <= 1'b1;
              snoozing_q   <= 1'b0;
            end else begin
              snooze_cnt_q <= snooze_cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          sound_q    <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sound_alarm      = sound_q;
  assign bus.snoozing         = snoozing_q;
  assign bus.alarm_active_idx = active_idx_q;
  assign bus.dbg_state        = state_q;
  assign bus.rd_alarm_ms_hr   = rd_word_d[15:12];
  assign bus.rd_alarm_ls_hr   = rd_word_d[11:8];
  assign bus.rd_alarm_ms_min  = rd_word_d[7:4];
  assign bus.rd_alarm_ls_min  = rd_word_d[3:0];

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// Directed self-checking bench for aclk_multi_alarm (4 channels, snooze 5, timeout 10).
module tb_aclk_multi_alarm;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  aclk_multi_alarm_if #(.NUM_ALARMS(4), .IDX_W(2)) bus ();

  aclk_multi_alarm #(
    .NUM_ALARMS(4), .IDX_W(2), .SNOOZE_MIN(5), .RING_TIMEOUT_MIN(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_time(input logic [3:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
    bus.cur_ms_hr  = h1;
    bus.cur_ls_hr  = h0;
    bus.cur_ms_min = m1;
    bus.cur_ls_min = m0;
  endtask

  task automatic tick_at(input logic [3:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    @(negedge clk);
    set_time(h1, h0, m1, m0);
    bus.minute_tick = 1'b1;
    @(negedge clk);
    bus.minute_tick = 1'b0;
  endtask

  // 12:00 matches no channel used by the bench.
  task automatic quiet_tick();
    tick_at(4'd1, 4'd2, 4'd0, 4'd0);
  endtask

  task automatic load_alarm(input logic [1:0] ch,
                            input logic [3:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
    @(negedge clk);
    bus.alarm_sel        = ch;
    bus.new_alarm_ms_hr  = h1;
    bus.new_alarm_ls_hr  = h0;
    bus.new_alarm_ms_min = m1;
    bus.new_alarm_ls_min = m0;
    bus.load_new_a       = 1'b1;
    @(negedge clk);
    bus.load_new_a = 1'b0;
  endtask

  task automatic press(input logic snz, input logic stp);
    @(negedge clk);
    bus.snooze_button = snz;
    bus.stop_button   = stp;
    @(negedge clk);
    bus.snooze_button = 1'b0;
    bus.stop_button   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL reset_sound: got %b want 0", bus.sound_alarm); end
    checks++; if (bus.snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %b want 0", bus.snoozing); end
    checks++; if (bus.alarm_active_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.alarm_active_idx); end
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
    for (int c = 0; c < 4; c++) begin
      bus.alarm_sel = 2'(c);
      #1;
      checks++;
      if ({bus.rd_alarm_ms_hr, bus.rd_alarm_ls_hr, bus.rd_alarm_ms_min, bus.rd_alarm_ls_min} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_readback ch%0d: got %h%h:%h%h want 00:00", c,
                 bus.rd_alarm_ms_hr, bus.rd_alarm_ls_hr, bus.rd_alarm_ms_min, bus.rd_alarm_ls_min);
      end
    end
  endtask

  task automatic test_basic_match();
    load_alarm(2'd2, 4'd0, 4'd7, 4'd3, 4'd0);
    bus.alarm_sel = 2'd2;
    #1;
    checks++;
    if ({bus.rd_alarm_ms_hr, bus.rd_alarm_ls_hr, bus.rd_alarm_ms_min, bus.rd_alarm_ls_min} !== 16'h0730) begin
      errors++;
      $display("FAIL readback_ch2: got %h%h:%h%h want 07:30",
               bus.rd_alarm_ms_hr, bus.rd_alarm_ls_hr, bus.rd_alarm_ms_min, bus.rd_alarm_ls_min);
    end
    bus.alarm_en = 4'b0100;
    tick_at(4'd0, 4'd7, 4'd3, 4'd0);
    checks++; if (bus.sound_alarm !== 1'b1) begin errors++; $display("FAIL basic_ring: sound=%b want 1", bus.sound_alarm); end
    checks++; if (bus.alarm_active_idx !== 2'd2) begin errors++; $display("FAIL basic_idx: got %0d want 2", bus.alarm_active_idx); end
    checks++; if (bus.dbg_state !== S_RING) begin errors++; $display("FAIL basic_state: got %0d want 1", bus.dbg_state); end
    press(1'b0, 1'b1);
    checks++; if (bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL basic_stop: sound=%b want 0", bus.sound_alarm); end
    bus.alarm_en = 4'b0000;
    tick_at(4'd0, 4'd7, 4'd3, 4'd0);
    checks++; if (bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL disabled_no_ring: sound=%b want 0", bus.sound_alarm); end
  endtask

  task automatic test_lowest_index();
    load_alarm(2'd0, 4'd0, 4'd6, 4'd0, 4'd0);
    load_alarm(2'd3, 4'd0, 4'd6, 4'd0, 4'd0);
    bus.alarm_en = 4'b1001;
    tick_at(4'd0, 4'd6, 4'd0, 4'd0);
    checks++; if (bus.sound_alarm !== 1'b1) begin errors++; $display("FAIL prio_ring: sound=%b want 1", bus.sound_alarm); end
    checks++; if (bus.alarm_active_idx !== 2'd0) begin errors++; $display("FAIL prio_idx: got %0d want 0", bus.alarm_active_idx); end
    press(1'b0, 1'b1);
    checks++; if (bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL prio_stop_sound: sound=%b want 0", bus.sound_alarm); end
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL prio_stop_state: got %0d want 0", bus.dbg_state); end
    press(1'b1, 1'b0);
    checks++; if (bus.snoozing !== 1'b0 || bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL idle_snooze_ignored: snoozing=%b state=%0d want 0/0", bus.snoozing, bus.dbg_state); end
  endtask

  task automatic test_snooze();
    load_alarm(2'd1, 4'd0, 4'd9, 4'd0, 4'd0);
    bus.alarm_en = 4'b0010;
    tick_at(4'd0, 4'd9, 4'd0, 4'd0);
    checks++; if (bus.sound_alarm !== 1'b1 || bus.alarm_active_idx !== 2'd1) begin errors++; $display("FAIL snz_ring: sound=%b idx=%0d want 1/1", bus.sound_alarm, bus.alarm_active_idx); end
    press(1'b1, 1'b0);
    checks++; if (bus.snoozing !== 1'b1 || bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL snz_enter: snoozing=%b sound=%b want 1/0", bus.snoozing, bus.sound_alarm); end
    for (int k = 1; k <= 4; k++) begin
      quiet_tick();
      if (k == 2) press(1'b1, 1'b0);
      checks++;
      if (bus.snoozing !== 1'b1 || bus.sound_alarm !== 1'b0) begin
        errors++;
        $display("FAIL snz_hold tick%0d: snoozing=%b sound=%b want 1/0", k, bus.snoozing, bus.sound_alarm);
      end
    end
    quiet_tick();
    checks++; if (bus.sound_alarm !== 1'b1 || bus.snoozing !== 1'b0) begin errors++; $display("FAIL snz_rering: sound=%b snoozing=%b want 1/0", bus.sound_alarm, bus.snoozing); end
    press(1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    bus.alarm_en = 4'b0010;
    tick_at(4'd0, 4'd9, 4'd0, 4'd0);
    for (int k = 1; k <= 9; k++) begin
      quiet_tick();
      checks++; if (bus.sound_alarm !== 1'b1) begin errors++; $display("FAIL timeout_hold tick%0d: sound=%b want 1", k, bus.sound_alarm); end
    end
    quiet_tick();
    checks++; if (bus.sound_alarm !== 1'b0 || bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL timeout_end: sound=%b state=%0d want 0/0", bus.sound_alarm, bus.dbg_state); end

    // Restart: ch0 (06:00) matches on the 5th tick of a ch1 ring.
    bus.alarm_en = 4'b0011;
    tick_at(4'd0, 4'd9, 4'd0, 4'd0);
    for (int k = 1; k <= 4; k++) quiet_tick();
    tick_at(4'd0, 4'd6, 4'd0, 4'd0);
    checks++; if (bus.sound_alarm !== 1'b1 || bus.alarm_active_idx !== 2'd0) begin errors++; $display("FAIL restart_idx: sound=%b idx=%0d want 1/0", bus.sound_alarm, bus.alarm_active_idx); end
    for (int k = 1; k <= 9; k++) begin
      quiet_tick();
      checks++; if (bus.sound_alarm !== 1'b1) begin errors++; $display("FAIL restart_hold tick%0d: sound=%b want 1", k, bus.sound_alarm); end
    end
    quiet_tick();
    checks++; if (bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL restart_end: sound=%b want 0", bus.sound_alarm); end
  endtask

  task automatic test_no_direct_trigger();
    bus.alarm_en = 4'b0000;
    @(negedge clk);
    set_time(4'd0, 4'd8, 4'd1, 4'd5);
    repeat (2) @(negedge clk);
    bus.alarm_en = 4'b0001;
    load_alarm(2'd0, 4'd0, 4'd8, 4'd1, 4'd5);
    repeat (2) @(negedge clk);
    checks++; if (bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL load_no_trigger: sound=%b want 0", bus.sound_alarm); end
    tick_at(4'd0, 4'd8, 4'd1, 4'd6);
    checks++; if (bus.sound_alarm !== 1'b0 || bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL next_tick_no_ring: sound=%b state=%0d want 0/0", bus.sound_alarm, bus.dbg_state); end
  endtask

  task automatic test_enable_clear();
    bus.alarm_en = 4'b0010;
    tick_at(4'd0, 4'd9, 4'd0, 4'd0);
    load_alarm(2'd1, 4'd1, 4'd0, 4'd4, 4'd5);
    checks++; if (bus.sound_alarm !== 1'b1) begin errors++; $display("FAIL rewrite_active: sound=%b want 1", bus.sound_alarm); end
    @(negedge clk);
    bus.alarm_en = 4'b0000;
    @(negedge clk);
    checks++; if (bus.dbg_state !== S_IDLE || bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL en_clear: state=%0d sound=%b want 0/0", bus.dbg_state, bus.sound_alarm); end
    bus.alarm_en = 4'b0010;
    tick_at(4'd1, 4'd0, 4'd4, 4'd5);
    checks++; if (bus.sound_alarm !== 1'b1) begin errors++; $display("FAIL new_value_ring: sound=%b want 1", bus.sound_alarm); end
    press(1'b1, 1'b1);
    checks++; if (bus.dbg_state !== S_IDLE || bus.snoozing !== 1'b0 || bus.sound_alarm !== 1'b0) begin errors++; $display("FAIL stop_over_snooze: state=%0d snoozing=%b sound=%b want 0/0/0", bus.dbg_state, bus.snoozing, bus.sound_alarm); end
  endtask

  task automatic test_reset_mid_snooze();
    tick_at(4'd1, 4'd0, 4'd4, 4'd5);
    press(1'b1, 1'b0);
    checks++; if (bus.snoozing !== 1'b1 || bus.dbg_state !== S_SNZ) begin errors++; $display("FAIL pre_reset_snooze: snoozing=%b state=%0d want 1/2", bus.snoozing, bus.dbg_state); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.sound_alarm !== 1'b0 || bus.snoozing !== 1'b0 || bus.alarm_active_idx !== 2'd0 || bus.dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL async_reset: sound=%b snoozing=%b idx=%0d state=%0d want 0/0/0/0",
               bus.sound_alarm, bus.snoozing, bus.alarm_active_idx, bus.dbg_state);
    end
    for (int c = 0; c < 4; c++) begin
      bus.alarm_sel = 2'(c);
      #1;
      checks++;
      if ({bus.rd_alarm_ms_hr, bus.rd_alarm_ls_hr, bus.rd_alarm_ms_min, bus.rd_alarm_ls_min} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_lost ch%0d: got %h%h:%h%h want 00:00", c,
                 bus.rd_alarm_ms_hr, bus.rd_alarm_ls_hr, bus.rd_alarm_ms_min, bus.rd_alarm_ls_min);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.minute_tick      = 1'b0;
    bus.load_new_a       = 1'b0;
    bus.alarm_sel        = '0;
    bus.alarm_en         = '0;
    bus.snooze_button    = 1'b0;
    bus.stop_button      = 1'b0;
    bus.new_alarm_ms_hr  = '0;
    bus.new_alarm_ls_hr  = '0;
    bus.new_alarm_ms_min = '0;
    bus.new_alarm_ls_min = '0;
    set_time(4'd0, 4'd0, 4'd0, 4'd0);

    test_reset();
    test_basic_match();
    test_lowest_index();
    test_snooze();
    test_timeout();
    test_no_direct_trigger();
    test_enable_clear();
    test_reset_mid_snooze();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aclk_multi_alarm.md
Name: aclk_multi_alarm

Overview:
- Parametrised successor to the single-alarm register and compare path of the alarm clock.
- Holds NUM_ALARMS independent BCD alarm times, each with its own enable bit.
- Detects a match against the current time once per minute and runs a ringing/snooze/timeout state machine that drives sound_alarm.
- Sits between the time counter/key register and the display/sounder.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..16).
- IDX_W, 2, width of channel index; NUM_ALARMS <= 2**IDX_W.
- SNOOZE_MIN, 5, minutes from snooze press to re-ring (1..255).
- RING_TIMEOUT_MIN, 10, minutes of unattended ringing before auto-stop (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- minute_tick  in  1  one-cycle pulse; cur_* already show the newly advanced minute in this cycle.
- cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min  in  4 each  current time, BCD.
- load_new_a  in  1  one-cycle write strobe for alarm channel alarm_sel.
- alarm_sel  in  IDX_W  channel for write and readback.
- new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min  in  4 each  alarm value to write.
- alarm_en  in  NUM_ALARMS  per-channel enable (level).
- snooze_button  in  1  one-cycle pulse, debounced upstream.
- stop_button  in  1  one-cycle pulse, debounced upstream.
- sound_alarm  out  1  high while in RINGING.
- snoozing  out  1  high while in SNOOZE.
- alarm_active_idx  out  IDX_W  channel that caused the current ring/snooze.
- rd_alarm_ms_hr, rd_alarm_ls_hr, rd_alarm_ms_min, rd_alarm_ls_min  out  4 each  stored value of channel alarm_sel (combinational readback).

Behaviour:
- Reset (async, reset=0):
  - All alarm registers = 0000 (00:00).
  - State = IDLE; sound_alarm=0, snoozing=0, alarm_active_idx=0.
  - Ring and snooze counters = 0.
- Alarm write:
  - On clk edge with load_new_a=1 and alarm_sel<NUM_ALARMS, that channel stores the new_alarm_* digits.
  - alarm_sel>=NUM_ALARMS: write ignored and readback = 0.
  - Digits are stored unchecked; invalid BCD simply never matches.
- Match:
  - match[i] = alarm_en[i] AND all four cur_* digits equal alarm i.
  - trigger = minute_tick AND any match[i]. Matches outside a minute_tick cycle are ignored, so loading a time or alarm never triggers directly.
  - Several matches in the same tick: lowest index wins.
- FSM states: IDLE, RINGING, SNOOZE (8-bit ring_cnt, 8-bit snooze_cnt).
  - IDLE:
    - trigger -> RINGING; alarm_active_idx = winning index; ring_cnt = 0.
    - snooze/stop presses ignored.
  - RINGING:
    - stop_button -> IDLE.
    - Else snooze_button -> SNOOZE with snooze_cnt = SNOOZE_MIN.
    - Else trigger -> stay RINGING; ring_cnt = 0; alarm_active_idx = new winner.
    - Else minute_tick increments ring_cnt. When ring_cnt reaches RING_TIMEOUT_MIN-1 on a tick -> IDLE, so the ring lasts exactly RING_TIMEOUT_MIN ticks.
  - SNOOZE:
    - stop_button -> IDLE.
    - Else trigger -> RINGING immediately; ring_cnt = 0; alarm_active_idx = new winner.
    - Else minute_tick decrements snooze_cnt. The tick that takes it 1->0 moves to RINGING with ring_cnt = 0.
    - Repeated snooze_button presses are ignored (no extension).
- Priority in any cycle: reset > stop_button > snooze_button > trigger > tick counting.
- Clearing alarm_en[alarm_active_idx] while in RINGING or SNOOZE -> IDLE on the next edge. This has priority below stop_button and above all else.
- Writing a new value to the active channel mid-ring does not stop the ring.
- Outputs are registered, so sound_alarm asserts 1 cycle after the triggering minute_tick edge.
- Reset mid-ring or mid-snooze returns to IDLE instantly (asynchronous); alarm values are lost.

Test Plan:
1. Reset, then load ch2=07:30 with alarm_en=0100. Drive cur=07:30 with a minute_tick -> sound_alarm=1 next cycle, alarm_active_idx=2. Repeat with alarm_en=0000 -> no ring.
2. ch0=ch3=06:00, both enabled; tick at 06:00 -> alarm_active_idx=0. Then stop_button -> sound_alarm=0, state IDLE, next cycle.
3. Ringing ch1, press snooze -> snoozing=1, sound_alarm=0. After 4 ticks still snoozing; 5th tick -> sound_alarm=1, snoozing=0. An extra snooze press at tick 2 does not extend the snooze.
4. Ringing with no input: 9 ticks -> still ringing; 10th tick -> sound_alarm=0. A second alarm matching at tick 5 restarts the count, requiring 10 more ticks.
5. cur=08:15 held, then load ch0=08:15 with no tick -> no ring. Next tick with cur=08:16 -> no ring.
6. Ringing ch1: clear alarm_en[1] -> IDLE next cycle. Assert stop and snooze in the same cycle -> IDLE. Assert reset=0 mid-snooze -> all outputs 0 and readback of every channel = 00:00.
